// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: state encodings, the NOP word and the default reset PC.
// Imported by fetch_unit and pc_next_sel.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_TRAP  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// Next-PC selection: PC+4 adder, redirect mux and redirect alignment check.
// FETCH_MISALIGN_CHECK_EN keeps the raw target and flags low bits; otherwise they are cleared.
module pc_next_sel
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        pc_src_i,
    input  logic [31:0] pc_target_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] pc_next_o,
    output logic        misalign_o
);

    logic [31:0] target_aligned;

    assign pc_plus4_o = pc_i + 32'd4;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target_aligned = pc_target_i;
    assign misalign_o     = pc_src_i && (pc_target_i[1:0] != 2'b00);
`else
    assign target_aligned = pc_target_i & 32'hFFFF_FFFC;
    assign misalign_o     = 1'b0;
`endif

    assign pc_next_o = pc_src_i ? target_aligned : pc_plus4_o;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a ready handshake and holds the word until consumed.
// Define FETCH_MISALIGN_CHECK_EN to trap on misaligned redirect targets.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    input  logic        stall,
    input  logic        pcSrc,
    input  logic [31:0] pcTarget,
    output logic        instrValid,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [2:0]  f3,
    output logic [6:0]  f7,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic        misaligned
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_next;
    logic [31:0]  pc_plus4;
    logic         redirect_misaligned;

    pc_next_sel u_pc_next_sel (
        .pc_i        (pc_q),
        .pc_src_i    (pcSrc),
        .pc_target_i (pcTarget),
        .pc_plus4_o  (pc_plus4),
        .pc_next_o   (pc_next),
        .misalign_o  (redirect_misaligned)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imemReady) begin
                    instr_d = imemData;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Redirect inputs matter only on the consuming cycle.
                if (!stall) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (redirect_misaligned) begin
                        state_d = ST_TRAP;
                    end else begin
                        pc_d    = pc_next;
                        state_d = ST_FETCH;
                    end
`else
                    pc_d    = pc_next;
                    state_d = ST_FETCH;
`endif
                end
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
        endcase
    end

    assign imemReq    = (state_q == ST_FETCH);
    assign imemAddr   = pc_q;
    assign instrValid = (state_q == ST_HOLD);
    assign instr      = instr_q;
    assign op         = instr_q[6:0];
    assign f3         = instr_q[14:12];
    assign f7         = instr_q[31:25];
    assign pc         = pc_q;
    assign pcPlus4    = pc_plus4;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned = (state_q == ST_TRAP);
`else
    assign misaligned = 1'b0;
    logic unused_misalign;
    assign unused_misalign = redirect_misaligned;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected {pc, instr} pushed on each accepted fetch,
// popped when instrValid is seen; a second instance checks PC wraparound at 32'hFFFF_FFFC.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imemReq, instrValid, misaligned;
    logic [31:0] imemAddr, imemData, instr, pc, pcPlus4, pcTarget;
    logic        imemReady, stall, pcSrc;
    logic [6:0]  op, f7;
    logic [2:0]  f3;

    logic        w_req, w_valid, w_mis;
    logic [31:0] w_addr, w_data, w_instr, w_pc, w_pc4;
    logic [6:0]  w_op, w_f7;
    logic [2:0]  w_f3;

    logic [31:0] mem [0:255];
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    assign imemData = mem[imemAddr[9:2]];
    assign w_data   = mem[w_addr[9:2]];

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .reset(reset), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemReady(imemReady), .imemData(imemData), .stall(stall), .pcSrc(pcSrc),
        .pcTarget(pcTarget), .instrValid(instrValid), .instr(instr), .op(op),
        .f3(f3), .f7(f7), .pc(pc), .pcPlus4(pcPlus4), .misaligned(misaligned)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(reset), .imemReq(w_req), .imemAddr(w_addr),
        .imemReady(1'b1), .imemData(w_data), .stall(1'b0), .pcSrc(1'b0),
        .pcTarget(32'h0000_0000), .instrValid(w_valid), .instr(w_instr), .op(w_op),
        .f3(w_f3), .f7(w_f7), .pc(w_pc), .pcPlus4(w_pc4), .misaligned(w_mis)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [31:0] p);
        exp_t e;
        e.pc    = p;
        e.instr = mem[p[9:2]];
        sb_q.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_valid"}, {31'd0, instrValid}, 32'd1);
            chk({tag, "_instr"}, instr, e.instr);
            chk({tag, "_pc"}, pc, e.pc);
            $display("txn %s pc=%h instr=%h", tag, pc, instr);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013 + (i << 7) + (i << 20);
        mem[0]  = 32'h0050_0093;
        mem[1]  = 32'h4021_81B3;
        mem[64] = 32'hFE20_8EE3;

        reset = 1'b1; imemReady = 1'b0; stall = 1'b1; pcSrc = 1'b0; pcTarget = 32'h0;
        tick(); tick();
        chk("rst_req", {31'd0, imemReq}, 32'd0);
        chk("rst_valid", {31'd0, instrValid}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_mis", {31'd0, misaligned}, 32'd0);
        chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);

        reset = 1'b0; imemReady = 1'b1;
        tick();
        chk("t1_req", {31'd0, imemReq}, 32'd1);
        chk("t1_addr", imemAddr, 32'h0);
        chk("t1_valid", {31'd0, instrValid}, 32'd0);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        push_exp(32'h0);
        tick();
        pop_chk("first");
        chk("first_op", {25'd0, op}, 32'h13);
        chk("first_f3", {29'd0, f3}, 32'd0);
        chk("first_f7", {25'd0, f7}, 32'd0);
        chk("first_pc4", pcPlus4, 32'h4);
        chk("first_req", {31'd0, imemReq}, 32'd0);
        chk("wrap_pc4", w_pc4, 32'h0);
        imemReady = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_instr", instr, 32'h0050_0093);
            chk("stall_pc", pc, 32'h0);
            chk("stall_valid", {31'd0, instrValid}, 32'd1);
            if (i == 0) chk("wrap_next_pc", w_pc, 32'h0);
        end
        stall = 1'b0;

        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wait_addr", imemAddr, 32'h4);
            chk("wait_req", {31'd0, imemReq}, 32'd1);
            chk("wait_valid", {31'd0, instrValid}, 32'd0);
            pcSrc    = (i == 1);
            pcTarget = 32'h0000_0200;
            if (i == 3) begin
                imemReady = 1'b1;
                push_exp(32'h4);
            end
        end
        tick();
        pop_chk("delayed");
        chk("delayed_f7", {25'd0, f7}, 32'h20);

        pcSrc = 1'b1; pcTarget = 32'h0000_0100; imemReady = 1'b0;
        tick();
        chk("redir_addr", imemAddr, 32'h100);
        chk("redir_req", {31'd0, imemReq}, 32'd1);
        pcSrc = 1'b0; imemReady = 1'b1;
        push_exp(32'h100);
        tick();
        pop_chk("redirect");

        pcSrc = 1'b1; pcTarget = 32'h0000_0102; imemReady = 1'b0;
        tick();
        pcSrc = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            chk("trap_mis", {31'd0, misaligned}, 32'd1);
            chk("trap_req", {31'd0, imemReq}, 32'd0);
            chk("trap_valid", {31'd0, instrValid}, 32'd0);
            chk("trap_pc", pc, 32'h100);
            imemReady = 1'b1;
            tick();
        end
        imemReady = 1'b0;
        reset = 1'b1;
        tick();
        chk("trap_rst_mis", {31'd0, misaligned}, 32'd0);
        reset = 1'b0;
        tick();
`else
        chk("mis_addr", imemAddr, 32'h100);
        chk("mis_flag", {31'd0, misaligned}, 32'd0);
        imemReady = 1'b1;
        push_exp(32'h100);
        tick();
        pop_chk("mis_redirect");
        imemReady = 1'b0;
        tick();
        chk("pre_rst_addr", imemAddr, 32'h104);
        chk("pre_rst_req", {31'd0, imemReq}, 32'd1);
        imemReady = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("async_req", {31'd0, imemReq}, 32'd0);
        chk("async_pc", pc, 32'h0);
        @(negedge clk);
        reset = 1'b0; imemReady = 1'b0;
        tick();
`endif
        chk("restart_addr", imemAddr, 32'h0);
        chk("restart_req", {31'd0, imemReq}, 32'd1);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
